// File: rtl/matmul_tile_scheduler.sv
// Tile scheduler for the systolic matmul core. Walks the output tiles of
// C = A*B one at a time and the K blocks of each tile, driving the A/B BRAM
// reads, core launches and C BRAM writes.
// Latency: K_BLOCKS*(2+READ_LATENCY+D)+1 cycles per tile, where D is the core
// latency from core_start to core_done. Backpressure: stalls in COMPUTE until
// core_done. start is accepted only while ready_o is high and is never queued.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   start_i/ready_o/done_o    run request, idle indication, end-of-matrix pulse
//   a_rd_*_o, b_rd_*_o        A/B block read enable and block address
//   core_start_o/acc_clr_o    one-cycle launch of a block MAC, accumulator clear
//   core_done_i               core finished the current block
//   c_wr_en_o/c_wr_addr_o     one write per finished output tile
//   row_blk_o/col_blk_o       current output tile coordinates
module matmul_tile_scheduler #(
    parameter int BLOCK_SIZE      = 2,
    parameter int INNER_DIMENSION = 64,
    parameter int NUM_ROW_BLOCKS  = 4,
    parameter int NUM_COL_BLOCKS  = 4,
    parameter int ADDR_WIDTH      = 16,
    parameter int READ_LATENCY    = 1,
    localparam int RB_W = (NUM_ROW_BLOCKS > 1) ? $clog2(NUM_ROW_BLOCKS) : 1,
    localparam int CB_W = (NUM_COL_BLOCKS > 1) ? $clog2(NUM_COL_BLOCKS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic                  a_rd_en_o,
    output logic [ADDR_WIDTH-1:0] a_rd_addr_o,
    output logic                  b_rd_en_o,
    output logic [ADDR_WIDTH-1:0] b_rd_addr_o,
    output logic                  core_start_o,
    output logic                  core_acc_clr_o,
    input  logic                  core_done_i,
    output logic                  c_wr_en_o,
    output logic [ADDR_WIDTH-1:0] c_wr_addr_o,
    output logic [RB_W-1:0]       row_blk_o,
    output logic [CB_W-1:0]       col_blk_o
);

    localparam int K_BLOCKS = INNER_DIMENSION / BLOCK_SIZE;
    localparam int KB_W     = (K_BLOCKS > 1) ? $clog2(K_BLOCKS) : 1;
    localparam int WT_W     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [KB_W-1:0] K_LAST   = KB_W'(K_BLOCKS - 1);
    localparam logic [RB_W-1:0] ROW_LAST = RB_W'(NUM_ROW_BLOCKS - 1);
    localparam logic [CB_W-1:0] COL_LAST = CB_W'(NUM_COL_BLOCKS - 1);
    localparam logic [WT_W-1:0] WT_LAST  = WT_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_COMPUTE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [RB_W-1:0] row_q, row_d;
    logic [CB_W-1:0] col_q, col_d;
    logic [KB_W-1:0] k_q, k_d;
    logic [WT_W-1:0] wait_q, wait_d;
    // Set once core_start has been issued in the current COMPUTE visit; core_done
    // is only honoured while this is set, so a level-high core_done left over
    // from the previous block cannot end the new block in its launch cycle.
    logic            issued_q, issued_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            k_q      <= '0;
            wait_q   <= '0;
            issued_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            k_q      <= k_d;
            wait_q   <= wait_d;
            issued_q <= issued_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        k_d      = k_q;
        wait_d   = wait_q;
        issued_d = issued_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    row_d    = '0;
                    col_d    = '0;
                    k_d      = '0;
                    wait_d   = '0;
                    issued_d = 1'b0;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == WT_LAST) begin
                    wait_d   = '0;
                    issued_d = 1'b0;
                    state_d  = S_COMPUTE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_COMPUTE: begin
                if (!issued_q) begin
                    issued_d = 1'b1;
                end else if (core_done_i) begin
                    issued_d = 1'b0;
                    if (k_q != K_LAST) begin
                        k_d     = k_q + 1'b1;
                        state_d = S_READ;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                k_d = '0;
                if (col_q != COL_LAST) begin
                    col_d   = col_q + 1'b1;
                    state_d = S_READ;
                end else if (row_q != ROW_LAST) begin
                    col_d   = '0;
                    row_d   = row_q + 1'b1;
                    state_d = S_READ;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Counters hold so the last tile position stays visible.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only.
    logic rd_phase;
    logic wr_phase;

    assign rd_phase = (state_q == S_READ);
    assign wr_phase = (state_q == S_WRITE);

    assign ready_o        = (state_q == S_IDLE);
    assign done_o         = (state_q == S_DONE);
    assign a_rd_en_o      = rd_phase;
    assign b_rd_en_o      = rd_phase;
    assign core_start_o   = (state_q == S_COMPUTE) && !issued_q;
    assign core_acc_clr_o = core_start_o && (k_q == '0);
    assign c_wr_en_o      = wr_phase;
    assign row_blk_o      = row_q;
    assign col_blk_o      = col_q;

    // Addresses are driven only alongside their enable and read 0 otherwise.
    assign a_rd_addr_o = rd_phase
        ? (ADDR_WIDTH'(row_q) * ADDR_WIDTH'(K_BLOCKS) + ADDR_WIDTH'(k_q))
        : '0;
    assign b_rd_addr_o = rd_phase
        ? (ADDR_WIDTH'(col_q) * ADDR_WIDTH'(K_BLOCKS) + ADDR_WIDTH'(k_q))
        : '0;
    assign c_wr_addr_o = wr_phase
        ? (ADDR_WIDTH'(row_q) * ADDR_WIDTH'(NUM_COL_BLOCKS) + ADDR_WIDTH'(col_q))
        : '0;

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Directed bench for matmul_tile_scheduler: three instances (1x1 tile with a
// 3-cycle core, 2x3 tiles with a 2-cycle core, 1x1 with READ_LATENCY=3 and
// core_done tied high), each driven by hand-timed start/reset sequences.
module tb_matmul_tile_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // u1: single tile, K_BLOCKS=2, READ_LATENCY=1, core latency 3
    logic        start_1, ready_1, done_1, are_1, bre_1, cs_1, clr_1, cd_1, cwe_1;
    logic [15:0] aa_1, ba_1, ca_1;
    logic [0:0]  row_1, col_1;
    // u2: 2x3 tiles, K_BLOCKS=2, READ_LATENCY=1, core latency 2
    logic        start_2, ready_2, done_2, are_2, bre_2, cs_2, clr_2, cd_2, cwe_2;
    logic [15:0] aa_2, ba_2, ca_2;
    logic [0:0]  row_2;
    logic [1:0]  col_2;
    // u3: single tile, K_BLOCKS=2, READ_LATENCY=3, core_done constantly high
    logic        start_3, ready_3, done_3, are_3, bre_3, cs_3, clr_3, cd_3, cwe_3;
    logic [15:0] aa_3, ba_3, ca_3;
    logic [0:0]  row_3, col_3;

    assign cd_3 = 1'b1;

    matmul_tile_scheduler #(.BLOCK_SIZE(2), .INNER_DIMENSION(4), .NUM_ROW_BLOCKS(1),
        .NUM_COL_BLOCKS(1), .ADDR_WIDTH(16), .READ_LATENCY(1)) u1 (
        .clk_i(clk), .rst_i(rst), .start_i(start_1), .ready_o(ready_1), .done_o(done_1),
        .a_rd_en_o(are_1), .a_rd_addr_o(aa_1), .b_rd_en_o(bre_1), .b_rd_addr_o(ba_1),
        .core_start_o(cs_1), .core_acc_clr_o(clr_1), .core_done_i(cd_1),
        .c_wr_en_o(cwe_1), .c_wr_addr_o(ca_1), .row_blk_o(row_1), .col_blk_o(col_1));

    matmul_tile_scheduler #(.BLOCK_SIZE(2), .INNER_DIMENSION(4), .NUM_ROW_BLOCKS(2),
        .NUM_COL_BLOCKS(3), .ADDR_WIDTH(16), .READ_LATENCY(1)) u2 (
        .clk_i(clk), .rst_i(rst), .start_i(start_2), .ready_o(ready_2), .done_o(done_2),
        .a_rd_en_o(are_2), .a_rd_addr_o(aa_2), .b_rd_en_o(bre_2), .b_rd_addr_o(ba_2),
        .core_start_o(cs_2), .core_acc_clr_o(clr_2), .core_done_i(cd_2),
        .c_wr_en_o(cwe_2), .c_wr_addr_o(ca_2), .row_blk_o(row_2), .col_blk_o(col_2));

    matmul_tile_scheduler #(.BLOCK_SIZE(2), .INNER_DIMENSION(4), .NUM_ROW_BLOCKS(1),
        .NUM_COL_BLOCKS(1), .ADDR_WIDTH(16), .READ_LATENCY(3)) u3 (
        .clk_i(clk), .rst_i(rst), .start_i(start_3), .ready_o(ready_3), .done_o(done_3),
        .a_rd_en_o(are_3), .a_rd_addr_o(aa_3), .b_rd_en_o(bre_3), .b_rd_addr_o(ba_3),
        .core_start_o(cs_3), .core_acc_clr_o(clr_3), .core_done_i(cd_3),
        .c_wr_en_o(cwe_3), .c_wr_addr_o(ca_3), .row_blk_o(row_3), .col_blk_o(col_3));

    // Core models: one-cycle core_done pulse D cycles after core_start.
    localparam int D_1 = 3;
    localparam int D_2 = 2;
    int cnt_1, cnt_2;

    always @(posedge clk) begin
        if (rst) cnt_1 <= 0;
        else if (cs_1) cnt_1 <= 1;
        else if (cnt_1 != 0 && cnt_1 < D_1) cnt_1 <= cnt_1 + 1;
        else cnt_1 <= 0;
    end
    always @(posedge clk) begin
        if (rst) cnt_2 <= 0;
        else if (cs_2) cnt_2 <= 1;
        else if (cnt_2 != 0 && cnt_2 < D_2) cnt_2 <= cnt_2 + 1;
        else cnt_2 <= 0;
    end
    assign cd_1 = (cnt_1 == D_1);
    assign cd_2 = (cnt_2 == D_2);

    int vectors    = 0;
    int miscompares = 0;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start_1 = 1'b0; start_2 = 1'b0; start_3 = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        vectors++;
        if ({ready_1, done_1, are_1, bre_1, cs_1, clr_1, cwe_1} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL reset_ctrl_u1 got=%b want=1000000",
                     {ready_1, done_1, are_1, bre_1, cs_1, clr_1, cwe_1});
        end
        vectors++;
        if ({ready_2, done_2, are_2, bre_2, cs_2, clr_2, cwe_2} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL reset_ctrl_u2 got=%b want=1000000",
                     {ready_2, done_2, are_2, bre_2, cs_2, clr_2, cwe_2});
        end
        vectors++;
        if ({aa_2, ba_2, ca_2, row_2, col_2} !== 51'd0) begin
            miscompares++;
            $display("FAIL reset_addr_u2 a=%0d b=%0d c=%0d row=%0d col=%0d want all 0",
                     aa_2, ba_2, ca_2, row_2, col_2);
        end
        for (int i = 0; i < 10; i++) begin
            tick;
            vectors++;
            if ({ready_2, done_2, are_2, cs_2, cwe_2, ready_3} !== 6'b100001) begin
                miscompares++;
                $display("FAIL idle_hold cyc=%0d got=%b want=100001", i,
                         {ready_2, done_2, are_2, cs_2, cwe_2, ready_3});
            end
        end
    endtask

    task automatic test_single_tile;
        logic [6:0] exp, obs;
        start_1 = 1'b1;
        tick;
        start_1 = 1'b0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            case (cyc)
                1, 7:    exp = 7'b1100000;
                3:       exp = 7'b0011000;
                9:       exp = 7'b0010000;
                13:      exp = 7'b0000100;
                14:      exp = 7'b0000010;
                15, 16:  exp = 7'b0000001;
                default: exp = 7'b0000000;
            endcase
            obs = {are_1, bre_1, cs_1, clr_1, cwe_1, done_1, ready_1};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL single_tile cyc=%0d got=%b want=%b", cyc, obs, exp);
            end
            if (cyc == 7) begin
                vectors++;
                if (aa_1 !== 16'd1 || ba_1 !== 16'd1) begin
                    miscompares++;
                    $display("FAIL single_tile_k1_addr a=%0d b=%0d want 1/1", aa_1, ba_1);
                end
            end
            tick;
        end
    endtask

    task automatic test_core_done_level;
        int cs_cyc[$];
        int rd_cyc[$];
        int clr_n, wr_at, done_at;
        clr_n = 0; wr_at = -1; done_at = -1;
        start_3 = 1'b1;
        tick;
        start_3 = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (cs_3) cs_cyc.push_back(cyc);
            if (are_3) rd_cyc.push_back(cyc);
            if (clr_3) clr_n += (cyc == 5) ? 1 : 100;
            if (cwe_3) wr_at = cyc;
            if (done_3) done_at = cyc;
            tick;
        end
        vectors++;
        if (cs_cyc.size() != 2 || cs_cyc[0] != 5 || cs_cyc[1] != 11) begin
            miscompares++;
            $display("FAIL level_done_core_start n=%0d first=%0d second=%0d want 2 at 5,11",
                     cs_cyc.size(), (cs_cyc.size() > 0) ? cs_cyc[0] : -1,
                     (cs_cyc.size() > 1) ? cs_cyc[1] : -1);
        end
        vectors++;
        if (rd_cyc.size() != 2 || rd_cyc[0] != 1 || rd_cyc[1] != 7) begin
            miscompares++;
            $display("FAIL level_done_reads n=%0d want 2 at 1,7", rd_cyc.size());
        end
        vectors++;
        if (clr_n != 1) begin
            miscompares++;
            $display("FAIL level_done_acc_clr score=%0d want 1", clr_n);
        end
        vectors++;
        if (wr_at != 13 || done_at != 14) begin
            miscompares++;
            $display("FAIL level_done_end wr=%0d done=%0d want 13/14", wr_at, done_at);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        start_1 = 1'b1;
        tick;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            if (cyc == 13) begin
                vectors++;
                if (cwe_1 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_write got=%b want=1", cwe_1);
                end
            end
            if (cyc == 14) begin
                vectors++;
                if (done_1 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_done got=%b want=1", done_1);
                end
            end
            if (cyc == 15) begin
                vectors++;
                if ({ready_1, are_1} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL b2b_idle got=%b want=10", {ready_1, are_1});
                end
            end
            if (cyc == 16) begin
                vectors++;
                if ({are_1, ready_1, aa_1, ba_1} !== {2'b10, 32'd0}) begin
                    miscompares++;
                    $display("FAIL b2b_restart en=%b rdy=%b a=%0d b=%0d want 1/0/0/0",
                             are_1, ready_1, aa_1, ba_1);
                end
            end
            tick;
        end
        start_1 = 1'b0;
        n = 0;
        while (!done_1 && n < 40) begin
            tick;
            n++;
        end
        vectors++;
        if (!done_1) begin
            miscompares++;
            $display("FAIL b2b_second_run_timeout done=%b want=1", done_1);
        end
        tick;
    endtask

    task automatic test_tile_sweep;
        int wr_addr[$];
        int wr_cyc[$];
        int dones;
        logic got;
        logic [15:0] cap_a, cap_b;
        dones = 0; got = 1'b0; cap_a = '0; cap_b = '0;
        start_2 = 1'b1;
        tick;
        start_2 = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            if (cwe_2) begin
                wr_addr.push_back(int'(ca_2));
                wr_cyc.push_back(cyc);
            end
            if (done_2) dones++;
            if (are_2 && row_2 == 1'b1 && col_2 == 2'd2 && !got) begin
                got = 1'b1;
                cap_a = aa_2;
                cap_b = ba_2;
            end
            tick;
        end
        vectors++;
        if (wr_addr.size() != 6 || dones != 1) begin
            miscompares++;
            $display("FAIL sweep_counts writes=%0d dones=%0d want 6/1", wr_addr.size(), dones);
        end
        for (int i = 0; i < wr_addr.size() && i < 6; i++) begin
            vectors++;
            if (wr_addr[i] != i) begin
                miscompares++;
                $display("FAIL sweep_wr_addr idx=%0d got=%0d want=%0d", i, wr_addr[i], i);
            end
            vectors++;
            if (wr_cyc[i] != 11 + 11 * i) begin
                miscompares++;
                $display("FAIL sweep_wr_cycle idx=%0d got=%0d want=%0d", i, wr_cyc[i], 11 + 11 * i);
            end
        end
        vectors++;
        if (!got || cap_a !== 16'd2 || cap_b !== 16'd4) begin
            miscompares++;
            $display("FAIL sweep_tile12_addr seen=%b a=%0d b=%0d want 1/2/4", got, cap_a, cap_b);
        end
        vectors++;
        if (ready_2 !== 1'b1) begin
            miscompares++;
            $display("FAIL sweep_end_ready got=%b want=1", ready_2);
        end
    endtask

    task automatic test_start_ignored;
        int n, wr, bad;
        start_2 = 1'b1;
        tick;
        start_2 = 1'b0;
        n = 0;
        while (!cs_2 && n < 20) begin
            tick;
            n++;
        end
        start_2 = 1'b1;
        tick;
        start_2 = 1'b0;
        vectors++;
        if ({are_2, ready_2} !== 2'b00) begin
            miscompares++;
            $display("FAIL start_in_compute got=%b want=00", {are_2, ready_2});
        end
        wr = 0; n = 0;
        while (!done_2 && n < 150) begin
            if (cwe_2) wr++;
            tick;
            n++;
        end
        vectors++;
        if (!done_2 || wr != 6 || row_2 !== 1'b1 || col_2 !== 2'd2) begin
            miscompares++;
            $display("FAIL start_ign_run done=%b writes=%0d row=%0d col=%0d want 1/6/1/2",
                     done_2, wr, row_2, col_2);
        end
        start_2 = 1'b1;
        tick;
        start_2 = 1'b0;
        vectors++;
        if ({ready_2, done_2, are_2} !== 3'b100) begin
            miscompares++;
            $display("FAIL start_in_done got=%b want=100", {ready_2, done_2, are_2});
        end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if ({ready_2, done_2, are_2} !== 3'b100) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL start_ign_idle bad_cycles=%0d want=0", bad);
        end
        start_2 = 1'b1;
        tick;
        start_2 = 1'b0;
        vectors++;
        if ({are_2, aa_2, ba_2, row_2, col_2} !== {1'b1, 35'd0}) begin
            miscompares++;
            $display("FAIL restart_cleared en=%b a=%0d b=%0d row=%0d col=%0d want 1/0/0/0/0",
                     are_2, aa_2, ba_2, row_2, col_2);
        end
    endtask

    task automatic test_reset_mid;
        int n, bad;
        n = 0;
        while (!(cs_2 && row_2 == 1'b0 && col_2 == 2'd1) && n < 60) begin
            tick;
            n++;
        end
        vectors++;
        if (!(cs_2 && row_2 == 1'b0 && col_2 == 2'd1)) begin
            miscompares++;
            $display("FAIL mid_reset_reach cs=%b row=%0d col=%0d want 1/0/1", cs_2, row_2, col_2);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        vectors++;
        if ({ready_2, cwe_2, done_2, are_2, row_2, col_2} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL mid_reset_state got=%b want=1000000",
                     {ready_2, cwe_2, done_2, are_2, row_2, col_2});
        end
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (cwe_2 || are_2 || done_2 || !ready_2) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL mid_reset_quiet bad_cycles=%0d want=0", bad);
        end
        start_2 = 1'b1;
        tick;
        start_2 = 1'b0;
        vectors++;
        if ({are_2, bre_2, aa_2, ba_2} !== {2'b11, 32'd0}) begin
            miscompares++;
            $display("FAIL mid_reset_restart en=%b%b a=%0d b=%0d want 11/0/0", are_2, bre_2, aa_2, ba_2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start_1 = 1'b0; start_2 = 1'b0; start_3 = 1'b0;
        test_reset;
        test_single_tile;
        test_core_done_level;
        test_back_to_back;
        test_tile_sweep;
        test_start_ignored;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/matmul_tile_scheduler.md
Name: matmul_tile_scheduler

Overview:
- Sequences the systolic matrix-multiply core and its BRAMs to compute C = A(M x K) * B(K x N), one BLOCK_SIZE x BLOCK_SIZE output tile at a time.
- For each output tile it walks the inner dimension in K_BLOCKS = INNER_DIMENSION/BLOCK_SIZE steps: issue the A/B BRAM reads, wait out the read latency, start the core, then wait for it to finish.
- After the last step of a tile it writes the accumulated result to the C BRAM.
- Sits between the top-level start/ready/done control port and the core + BRAM ports.

Parameters:
- BLOCK_SIZE, 2, systolic array dimension (N x N).
- INNER_DIMENSION, 64, shared K dimension; must be a multiple of BLOCK_SIZE.
- NUM_ROW_BLOCKS, 4, number of output tile rows (M/BLOCK_SIZE), >=1.
- NUM_COL_BLOCKS, 4, number of output tile columns (N/BLOCK_SIZE), >=1.
- ADDR_WIDTH, 16, BRAM address width.
- READ_LATENCY, 1, BRAM read latency in cycles, >=1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  start request; accepted only when ready=1.
- ready  out  1  high in IDLE.
- done  out  1  one-cycle pulse when the whole matrix is finished.
- a_rd_en  out  1  A BRAM read enable.
- a_rd_addr  out  ADDR_WIDTH  A block address = row_blk*K_BLOCKS + k_blk.
- b_rd_en  out  1  B BRAM read enable.
- b_rd_addr  out  ADDR_WIDTH  B block address = col_blk*K_BLOCKS + k_blk.
- core_start  out  1  one-cycle pulse that launches one block multiply-accumulate.
- core_acc_clr  out  1  valid with core_start; 1 when k_blk==0 (core clears its accumulator first).
- core_done  in  1  core finished the current block; level or pulse, sampled only in COMPUTE after core_start.
- c_wr_en  out  1  C BRAM write enable, one cycle per tile.
- c_wr_addr  out  ADDR_WIDTH  = row_blk*NUM_COL_BLOCKS + col_blk.
- row_blk  out  clog2(NUM_ROW_BLOCKS) (min 1)  current tile row.
- col_blk  out  clog2(NUM_COL_BLOCKS) (min 1)  current tile column.

Behaviour:
- States: IDLE, READ, WAIT, COMPUTE, WRITE, DONE.
- All outputs are decoded from the state register and counters; no combinational path from any input to any output.
- Reset: state=IDLE, row_blk=col_blk=k_blk=0, wait counter=0. After reset ready=1 and every other output is 0 (addresses 0).
- Reset mid-operation takes effect at the next edge, regardless of state. No partial write is issued after reset.
- IDLE:
  - ready=1.
  - If start=1, clear all counters and go to READ. Otherwise stay.
- READ (1 cycle):
  - a_rd_en=b_rd_en=1 with the addresses above.
  - Go to WAIT.
- WAIT (exactly READ_LATENCY cycles): counter counts 0..READ_LATENCY-1, then go to COMPUTE.
- COMPUTE:
  - core_start=1 only in the first COMPUTE cycle; core_acc_clr=(k_blk==0) in that same cycle.
  - core_done is ignored in the core_start cycle.
  - From the next cycle on, core_done=1 exits: if k_blk<K_BLOCKS-1, k_blk++ and go to READ; else go to WRITE.
  - With no core_done, stay indefinitely (no timeout).
- WRITE (1 cycle):
  - c_wr_en=1 with c_wr_addr.
  - Then k_blk=0.
  - If col_blk<NUM_COL_BLOCKS-1: col_blk++, go to READ.
  - Else if row_blk<NUM_ROW_BLOCKS-1: col_blk=0, row_blk++, go to READ.
  - Else go to DONE.
- DONE (1 cycle):
  - done=1.
  - Counters hold their last values; they are cleared on the next accepted start.
  - Go to IDLE.
- start outside IDLE is ignored (not queued). start held high through DONE is accepted again in the following IDLE cycle.
- Per-tile latency with core latency D (core_start to core_done, D>=1): K_BLOCKS*(2+READ_LATENCY+D)+1 cycles.
- Address arithmetic is unsigned and truncated to ADDR_WIDTH; the integrator ensures it fits.

Test Plan:
1. Reset, then idle: rst=1 for 2 cycles -> ready=1, done=0, all enables 0. Hold start=0 for 10 cycles -> state unchanged.
2. Single tile, BLOCK_SIZE=2, INNER_DIMENSION=4, NUM_ROW_BLOCKS=NUM_COL_BLOCKS=1, READ_LATENCY=1, core_done 3 cycles after core_start; start accepted at edge 0 ->
   - rd_en at cycle 1 (addr 0/0);
   - core_start+acc_clr=1 at cycle 3;
   - rd_en at cycle 7 (addr 1/1);
   - core_start with acc_clr=0 at cycle 9;
   - c_wr_en addr 0 at cycle 13;
   - done at cycle 14;
   - ready at cycle 15.
3. 2x3 tiles, K_BLOCKS=2 -> c_wr_addr sequence 0,1,2,3,4,5. First a_rd_addr of tile (1,2) = 2, b_rd_addr = 4. Exactly 6 c_wr_en pulses and 1 done.
4. READ_LATENCY=3, core_done held high constantly -> each k step takes 2+3+1 = 6 cycles; core_done in the core_start cycle does not advance the FSM.
5. Pulse start during COMPUTE and during DONE -> no restart and no extra done. A start during the IDLE cycle after DONE begins a new run with counters at 0.
6. Assert rst in COMPUTE of tile (0,1) -> next cycle ready=1, no c_wr_en. A fresh start gives first a_rd_addr=0, b_rd_addr=0.
